cordic_vectoring_engine: RTL and testbench

//  Iterative CORDIC vectoring-mode engine, the inverse of the rotation-mode angle path.

---
 rtl/cordic_vectoring_engine.sv | 145 ++++++++++++++
 tb/tb_cordic_vectoring_engine.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring_engine.sv
// Iterative CORDIC vectoring engine: rotates (x,y) onto the +x axis one
// micro-rotation per clock, returning atan2(y,x) and the gain-scaled magnitude.
// Angles use the same fixed-point format as the rotation datapath
// (LSB = 2^-ANGLE_FRAC rad).
module cordic_vectoring_engine #(
  parameter int WIDTH      = 32,
  parameter int ITER       = 16,
  parameter int ANGLE_FRAC = 29
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] angle_out,
  output logic [WIDTH-1:0] magnitude_out
);

  // Two guard bits absorb the CORDIC gain (~1.65 * sqrt(2)) on x and y.
  localparam int XW = WIDTH + 2;
  // The ROM is tabulated at 2^-29 rad/LSB and rescaled to ANGLE_FRAC.
  localparam int UP = (ANGLE_FRAC >= 29) ? ANGLE_FRAC - 29 : 0;
  localparam int DN = (ANGLE_FRAC <  29) ? 29 - ANGLE_FRAC : 0;
  localparam logic [4:0] LAST = 5'(ITER - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  function automatic logic signed [WIDTH-1:0] scale_ang(input longint v);
    longint r;
    r = (v <<< UP) >>> DN;
    return r[WIDTH-1:0];
  endfunction

  // round(atan(2^-i) * 2^29)
  function automatic longint atan_rom(input logic [4:0] idx);
    case (idx)
      5'd0:  return 64'd421657428;
      5'd1:  return 64'd248918915;
      5'd2:  return 64'd131521918;
      5'd3:  return 64'd66762579;
      5'd4:  return 64'd33510843;
      5'd5:  return 64'd16771758;
      5'd6:  return 64'd8387925;
      5'd7:  return 64'd4194219;
      5'd8:  return 64'd2097141;
      5'd9:  return 64'd1048575;
      5'd10: return 64'd524288;
      5'd11: return 64'd262144;
      5'd12: return 64'd131072;
      5'd13: return 64'd65536;
      5'd14: return 64'd32768;
      5'd15: return 64'd16384;
      5'd16: return 64'd8192;
      5'd17: return 64'd4096;
      5'd18: return 64'd2048;
      5'd19: return 64'd1024;
      5'd20: return 64'd512;
      5'd21: return 64'd256;
      5'd22: return 64'd128;
      5'd23: return 64'd64;
      default: return 64'd0;
    endcase
  endfunction

  localparam logic signed [WIDTH-1:0] PI_Q  = scale_ang(64'd1686629713);
  localparam logic signed [WIDTH-1:0] HPI_Q = scale_ang(64'd843314857);

  state_t                  state;
  logic [4:0]              i;
  logic signed [XW-1:0]    xr, yr;
  logic signed [WIDTH-1:0] zr;
  logic                    zero_f;

  logic signed [XW-1:0]    xs_in, ys_in, xsh, ysh;
  logic signed [WIDTH-1:0] atan_i, z_sat;

  assign xs_in  = {{2{x_in[WIDTH-1]}}, x_in};
  assign ys_in  = {{2{y_in[WIDTH-1]}}, y_in};
  assign xsh    = xr >>> i;
  assign ysh    = yr >>> i;
  assign atan_i = scale_ang(atan_rom(i));

  // Clamp the residual so the result never leaves [-pi,+pi]
  always_comb begin
    z_sat = zr;
    if (zr > PI_Q)       z_sat = PI_Q;
    else if (zr < -PI_Q) z_sat = -PI_Q;
  end

  // Control FSM and iterative datapath; results registered on FINISH
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      angle_out     <= '0;
      magnitude_out <= '0;
      i             <= '0;
      xr            <= '0;
      yr            <= '0;
      zr            <= '0;
      zero_f        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            i      <= '0;
            zero_f <= (x_in == '0) && (y_in == '0);
            state  <= RUN;
            // Fold left half-plane into the right so the iterations converge
            if (x_in[WIDTH-1] && !y_in[WIDTH-1]) begin
              xr <= ys_in;  yr <= -xs_in; zr <= HPI_Q;
            end else if (x_in[WIDTH-1]) begin
              xr <= -ys_in; yr <= xs_in;  zr <= -HPI_Q;
            end else begin
              xr <= xs_in;  yr <= ys_in;  zr <= '0;
            end
          end
        end
        RUN: begin
          if (!yr[XW-1]) begin
            xr <= xr + ysh; yr <= yr - xsh; zr <= zr + atan_i;
          end else begin
            xr <= xr - ysh; yr <= yr + xsh; zr <= zr - atan_i;
          end
          i <= i + 5'd1;
          if (i == LAST) state <= FINISH;
        end
        FINISH: begin
          angle_out     <= zero_f ? '0 : z_sat;
          magnitude_out <= zero_f ? '0 : xr[WIDTH-1:0];
          done          <= 1'b1;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vectoring_engine.sv
// Scoreboard bench for cordic_vectoring_engine: the driver pushes hand-computed
// results, an independent monitor pops and checks on every done pulse.
module tb_cordic_vectoring_engine;
  localparam int WIDTH = 32;
  localparam int ITER  = 16;
  localparam int LAT   = ITER + 1;   // edges from accept to the done edge
  localparam int ATOL  = 32768;

  localparam int P28   = 268435456;
  localparam int MAG1  = 442048846;  // K * 2^28
  localparam int MAGR2 = 625151466;  // K * 2^28 * sqrt(2)
  localparam int MAG5  = 552561058;  // K * 5 * 2^26

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] x_in = '0, y_in = '0;
  logic             busy, done;
  logic [WIDTH-1:0] angle_out, magnitude_out;

  cordic_vectoring_engine #(.WIDTH(WIDTH), .ITER(ITER), .ANGLE_FRAC(29)) dut (
    .clock(clk), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
    .busy(busy), .done(done), .angle_out(angle_out), .magnitude_out(magnitude_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string  name;
    int     ea;
    int     em;
    int     atol;
    longint ecyc;
  } exp_t;

  exp_t   sb[$];
  longint cyc = 0;
  int     n_cmp = 0, n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input bit ok, input longint act, input longint req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0d, wanted %0d", nm, act, req);
    end
  endtask

  function automatic longint labs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin : mon
    exp_t   e;
    longint a, m;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1'b0, 1, 0);
      end else begin
        e = sb.pop_front();
        a = longint'($signed(angle_out));
        m = longint'($signed(magnitude_out));
        check({e.name, "_angle"}, labs(a - e.ea) <= e.atol, a, e.ea);
        check({e.name, "_mag"}, labs(m - e.em) <= e.em / 10000, m, e.em);
        check({e.name, "_latency"}, cyc == e.ecyc, cyc, e.ecyc);
      end
    end
  end

  task automatic issue(input string nm, input int x, input int y, input int ea,
                       input int em, input int atol, input bit push);
    @(negedge clk);
    x_in = x; y_in = y; start = 1'b1;
    if (push) sb.push_back('{nm, ea, em, atol, cyc + 1 + LAT});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (busy) check({nm, "_timeout"}, 1'b0, 1, 0);
  endtask

  task automatic run(input string nm, input int x, input int y, input int ea,
                     input int em, input int atol);
    issue(nm, x, y, ea, em, atol, 1'b1);
    wait_idle(nm);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, wanted finish");
    $fatal(1);
  end

  initial begin : stim
    longint acc;
    repeat (3) @(negedge clk);
    check("rst_busy",  busy == 1'b0, busy, 0);
    check("rst_done",  done == 1'b0, done, 0);
    check("rst_angle", angle_out == '0, angle_out, 0);
    check("rst_mag",   magnitude_out == '0, magnitude_out, 0);
    reset = 1'b0;

    run("q1_diag",   P28,  P28,  421657428,   MAGR2, ATOL);
    run("neg_x",    -P28,  0,    1686629713,  MAG1,  ATOL);
    run("neg_y",     0,   -P28, -843314857,   MAG1,  ATOL);
    run("zero",      0,    0,    0,           0,     0);
    run("pos_x",     P28,  0,    0,           MAG1,  ATOL);
    run("pos_y",     0,    P28,  843314857,   MAG1,  ATOL);
    run("q3_diag",  -P28, -P28, -1264972285,  MAGR2, ATOL);
    run("q1_34",     201326592,  268435456,  497837831,  MAG5, ATOL);
    run("q3_34",    -201326592, -268435456, -1188791882, MAG5, ATOL);

    // Extra starts while busy must be dropped, not queued
    issue("ignore", P28, -P28, -421657428, MAGR2, ATOL, 1'b1);
    @(negedge clk);
    x_in = -100000000; y_in = 5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    x_in = 7; y_in = -99999999; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("ignore");
    repeat (20) @(negedge clk);

    // start held high: back-to-back ops, one every ITER+2 cycles
    @(negedge clk);
    x_in = P28; y_in = P28; start = 1'b1;
    acc = cyc + 1;
    sb.push_back('{"b2b_a", 421657428, MAGR2, ATOL, acc + LAT});
    @(negedge clk);
    x_in = -201326592; y_in = 268435456;
    sb.push_back('{"b2b_b", 1188791882, MAG5, ATOL, acc + ITER + 2 + LAT});
    repeat (ITER + 2) @(negedge clk);
    start = 1'b0;
    wait_idle("b2b");

    // Reset at cycle 8 of a run drops the op and clears the outputs
    issue("rst_mid", P28, P28, 0, 0, 0, 1'b0);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy",  busy == 1'b0, busy, 0);
    check("mid_rst_done",  done == 1'b0, done, 0);
    check("mid_rst_angle", angle_out == '0, angle_out, 0);
    check("mid_rst_mag",   magnitude_out == '0, magnitude_out, 0);
    reset = 1'b0;
    run("post_rst", P28, -P28, -421657428, MAGR2, ATOL);

    repeat (30) @(negedge clk);
    check("sb_drained", sb.size() == 0, sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
